// File: rtl/run_length_detector.sv
// Serial run detector: counts consecutive 1s on x, strobes y at the end of a
// qualifying run and registers the run length with a sticky saturation flag.
module run_length_detector #(
    parameter int CNT_W   = 4,
    parameter int MIN_RUN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             clr_sat,
    output logic             y,
    output logic             run_valid,
    output logic [CNT_W-1:0] run_len,
    output logic             sat_flag,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        LONG = 2'b11,
        SAT  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] MAXC  = '1;
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_RUN);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_set;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y       = 1'b0;
        if (en) begin
            if (x) begin
                cnt_d = (cnt_q == MAXC) ? MAXC : cnt_q + CNT_W'(1);
                // SAT first so MIN_RUN == MAXC still lands in SAT
                if (cnt_d == MAXC)
                    state_d = SAT;
                else if (cnt_d >= MIN_C)
                    state_d = LONG;
                else
                    state_d = RUN;
            end else begin
                cnt_d   = '0;
                state_d = IDLE;
                y       = (state_q == LONG) || (state_q == SAT);
            end
        end
    end

    assign sat_set = (state_d == SAT) && (state_q != SAT);
    assign state   = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            run_valid <= 1'b0;
            run_len   <= '0;
            sat_flag  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            run_valid <= y;
            if (y)
                run_len <= cnt_q;
            if (sat_set)
                sat_flag <= 1'b1;
            else if (clr_sat)
                sat_flag <= 1'b0;
        end
    end

endmodule
